// File: rtl/mem_arbiter.sv
// Two-requester (fetch/data) arbiter onto one memory port; grant to memReq is 1 cycle and completion is combinational on memReady.
// Optional wait-limit watchdog is enabled by defining MEM_ARB_TIMEOUT_EN.
module mem_arbiter #(
  parameter int ADDR_W         = 32,
  parameter int DATA_W         = 32,
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              ifReq,
  input  logic [ADDR_W-1:0] ifAddr,
  output logic [DATA_W-1:0] ifData,
  output logic              ifValid,
  input  logic              dReq,
  input  logic              dWrite,
  input  logic [ADDR_W-1:0] dAddr,
  input  logic [DATA_W-1:0] dWData,
  output logic [DATA_W-1:0] dRData,
  output logic              dValid,
  output logic              memReq,
  output logic              memWrite,
  output logic [ADDR_W-1:0] memAddr,
  output logic [DATA_W-1:0] memWData,
  input  logic [DATA_W-1:0] memRData,
  input  logic              memReady,
  output logic              busy,
  output logic              timeoutErr
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FETCH = 2'd1,
    DATA  = 2'd2
  } state_t;

  state_t            state;
  state_t            state_nxt;
  logic              last_data;
  logic              last_data_nxt;
  logic              grant_data;
  logic              grant_fetch;
  logic              in_xfer;
  logic              timeout_hit;
  logic [ADDR_W-1:0] addr_q;
  logic              write_q;
  logic [DATA_W-1:0] wdata_q;

  assign in_xfer = (state == FETCH) || (state == DATA);

`ifdef MEM_ARB_TIMEOUT_EN
  localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 2);
  localparam logic [CNT_W-1:0] LIMIT = CNT_W'(TIMEOUT_CYCLES);

  logic [CNT_W-1:0] wait_cnt;

  assign timeout_hit = in_xfer && !memReady && (wait_cnt == LIMIT);

  always_ff @(posedge clk) begin
    if (reset) begin
      wait_cnt <= '0;
    end else if (grant_data || grant_fetch) begin
      wait_cnt <= '0;
    end else if (in_xfer && !memReady && !timeout_hit) begin
      wait_cnt <= wait_cnt + 1'b1;
    end
  end
`else
  logic unused_cfg;

  assign timeout_hit = 1'b0;
  assign unused_cfg  = (TIMEOUT_CYCLES != 0);
`endif

  // Data wins unless it was served last and fetch is also waiting, so the two alternate.
  always_comb begin
    state_nxt     = state;
    last_data_nxt = last_data;
    grant_data    = 1'b0;
    grant_fetch   = 1'b0;
    case (state)
      IDLE: begin
        if (dReq && (!ifReq || !last_data)) begin
          grant_data    = 1'b1;
          state_nxt     = DATA;
          last_data_nxt = 1'b1;
        end else if (ifReq) begin
          grant_fetch   = 1'b1;
          state_nxt     = FETCH;
          last_data_nxt = 1'b0;
        end
      end
      FETCH, DATA: begin
        if (memReady || timeout_hit) begin
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= IDLE;
      last_data <= 1'b0;
      addr_q    <= '0;
      write_q   <= 1'b0;
      wdata_q   <= '0;
    end else begin
      state     <= state_nxt;
      last_data <= last_data_nxt;
      if (grant_data) begin
        addr_q  <= dAddr;
        write_q <= dWrite;
        wdata_q <= dWData;
      end else if (grant_fetch) begin
        addr_q  <= ifAddr;
        write_q <= 1'b0;
        wdata_q <= '0;
      end
    end
  end

  // Reset masks every handshake output in the same cycle, ahead of any memReady.
  assign memReq     = in_xfer && !reset;
  assign busy       = in_xfer && !reset;
  assign memAddr    = addr_q;
  assign memWrite   = write_q;
  assign memWData   = wdata_q;
  assign ifValid    = !reset && (state == FETCH) && (memReady || timeout_hit);
  assign dValid     = !reset && (state == DATA) && (memReady || timeout_hit);
  assign ifData     = timeout_hit ? '0 : memRData;
  assign dRData     = timeout_hit ? '0 : memRData;
  assign timeoutErr = !reset && timeout_hit;

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter: single fetch, store with waits, contention, reset mid-fetch, timeout.
module tb_mem_arbiter;

  logic        clk = 1'b0;
  logic        reset;
  logic        ifReq;
  logic [31:0] ifAddr;
  logic [31:0] ifData;
  logic        ifValid;
  logic        dReq;
  logic        dWrite;
  logic [31:0] dAddr;
  logic [31:0] dWData;
  logic [31:0] dRData;
  logic        dValid;
  logic        memReq;
  logic        memWrite;
  logic [31:0] memAddr;
  logic [31:0] memWData;
  logic [31:0] memRData;
  logic        memReady;
  logic        busy;
  logic        timeoutErr;

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  mem_arbiter #(
    .ADDR_W(32),
    .DATA_W(32),
    .TIMEOUT_CYCLES(4)
  ) dut (
    .clk(clk),
    .reset(reset),
    .ifReq(ifReq),
    .ifAddr(ifAddr),
    .ifData(ifData),
    .ifValid(ifValid),
    .dReq(dReq),
    .dWrite(dWrite),
    .dAddr(dAddr),
    .dWData(dWData),
    .dRData(dRData),
    .dValid(dValid),
    .memReq(memReq),
    .memWrite(memWrite),
    .memAddr(memAddr),
    .memWData(memWData),
    .memRData(memRData),
    .memReady(memReady),
    .busy(busy),
    .timeoutErr(timeoutErr)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  // Drive on the falling edge, then let combinational outputs settle before sampling.
  task automatic step();
    @(negedge clk);
  endtask

  initial begin
    reset    = 1'b1;
    ifReq    = 1'b0;
    ifAddr   = '0;
    dReq     = 1'b0;
    dWrite   = 1'b0;
    dAddr    = '0;
    dWData   = '0;
    memRData = '0;
    memReady = 1'b0;

    // Reset state, with memReady high to show it is ignored.
    step();
    memReady = 1'b1;
    #1;
    check("rst_memReq", {31'b0, memReq}, 32'd0);
    check("rst_busy", {31'b0, busy}, 32'd0);
    check("rst_ifValid", {31'b0, ifValid}, 32'd0);
    check("rst_dValid", {31'b0, dValid}, 32'd0);
    check("rst_timeoutErr", {31'b0, timeoutErr}, 32'd0);
    step();
    reset    = 1'b0;
    memReady = 1'b1;
    #1;
    check("idle_ready_ignored", {30'b0, ifValid, dValid}, 32'd0);

    // Single fetch: grant cycle, one wait cycle, then ready.
    step();
    memReady = 1'b0;
    ifReq    = 1'b1;
    ifAddr   = 32'h100;
    #1;
    check("f_grant_memReq", {31'b0, memReq}, 32'd0);
    step();
    #1;
    check("f_memReq", {31'b0, memReq}, 32'd1);
    check("f_memAddr", memAddr, 32'h100);
    check("f_memWrite", {31'b0, memWrite}, 32'd0);
    check("f_busy", {31'b0, busy}, 32'd1);
    check("f_wait_ifValid", {31'b0, ifValid}, 32'd0);
    step();
    memReady = 1'b1;
    memRData = 32'h0000_0013;
    #1;
    check("f_ifValid", {31'b0, ifValid}, 32'd1);
    check("f_ifData", ifData, 32'h13);
    check("f_dValid", {31'b0, dValid}, 32'd0);
    step();
    ifReq    = 1'b0;
    memReady = 1'b0;
    #1;
    check("f_idle_busy", {31'b0, busy}, 32'd0);
    check("f_idle_memReq", {31'b0, memReq}, 32'd0);

    // Store with three wait cycles.
    step();
    dReq   = 1'b1;
    dWrite = 1'b1;
    dAddr  = 32'h40;
    dWData = 32'hDEAD_BEEF;
    #1;
    check("s_grant_busy", {31'b0, busy}, 32'd0);
    for (int i = 0; i < 4; i++) begin
      step();
      memReady = (i == 3);
      #1;
      check($sformatf("s_memReq_%0d", i), {31'b0, memReq}, 32'd1);
      check($sformatf("s_memWrite_%0d", i), {31'b0, memWrite}, 32'd1);
      check($sformatf("s_memAddr_%0d", i), memAddr, 32'h40);
      check($sformatf("s_memWData_%0d", i), memWData, 32'hDEAD_BEEF);
      check($sformatf("s_dValid_%0d", i), {31'b0, dValid}, (i == 3) ? 32'd1 : 32'd0);
    end
    step();
    dReq     = 1'b0;
    dWrite   = 1'b0;
    memReady = 1'b0;
    #1;
    check("s_idle_busy", {31'b0, busy}, 32'd0);

    // Contention: both held through a reset, memReady tied high; reset must beat the grant.
    step();
    reset    = 1'b1;
    ifReq    = 1'b1;
    ifAddr   = 32'h100;
    dReq     = 1'b1;
    dAddr    = 32'h2000;
    memReady = 1'b1;
    memRData = 32'h1234_5678;
    step();
    reset = 1'b0;
    #1;
    check("c_reset_beats_grant", {31'b0, busy}, 32'd0);
    for (int i = 0; i < 4; i++) begin
      step();
      #1;
      check($sformatf("c_memReq_%0d", i), {31'b0, memReq}, 32'd1);
      check($sformatf("c_memAddr_%0d", i), memAddr, (i % 2 == 0) ? 32'h2000 : 32'h100);
      check($sformatf("c_dValid_%0d", i), {31'b0, dValid}, (i % 2 == 0) ? 32'd1 : 32'd0);
      check($sformatf("c_ifValid_%0d", i), {31'b0, ifValid}, (i % 2 == 1) ? 32'd1 : 32'd0);
      if (i == 3) begin
        ifReq = 1'b0;
        dReq  = 1'b0;
      end
      step();
      #1;
      check($sformatf("c_idle_%0d", i), {31'b0, busy}, 32'd0);
    end

    // Reset on the second memReq cycle of a fetch, with memReady high.
    memReady = 1'b0;
    ifReq    = 1'b1;
    ifAddr   = 32'h300;
    step();
    #1;
    check("r_first_memReq", {31'b0, memReq}, 32'd1);
    step();
    reset    = 1'b1;
    memReady = 1'b1;
    #1;
    check("r_no_ifValid", {31'b0, ifValid}, 32'd0);
    step();
    reset    = 1'b0;
    ifReq    = 1'b0;
    memReady = 1'b0;
    #1;
    check("r_memReq_after", {31'b0, memReq}, 32'd0);
    check("r_busy_after", {31'b0, busy}, 32'd0);

    // Load with memReady held low.
    step();
    dReq     = 1'b1;
    dWrite   = 1'b0;
    dAddr    = 32'h80;
    memRData = 32'h55AA_55AA;
    #1;
    check("t_grant_busy", {31'b0, busy}, 32'd0);
`ifdef MEM_ARB_TIMEOUT_EN
    for (int c = 1; c <= 5; c++) begin
      step();
      #1;
      check($sformatf("t_memReq_%0d", c), {31'b0, memReq}, 32'd1);
      check($sformatf("t_dValid_%0d", c), {31'b0, dValid}, (c == 5) ? 32'd1 : 32'd0);
      check($sformatf("t_err_%0d", c), {31'b0, timeoutErr}, (c == 5) ? 32'd1 : 32'd0);
      if (c == 5) begin
        check("t_dRData_zero", dRData, 32'd0);
        dReq = 1'b0;
      end
    end
    step();
    #1;
    check("t_idle_busy", {31'b0, busy}, 32'd0);
    check("t_idle_err", {31'b0, timeoutErr}, 32'd0);
`else
    for (int c = 1; c <= 8; c++) begin
      step();
      #1;
      check($sformatf("t_memReq_%0d", c), {31'b0, memReq}, 32'd1);
      check($sformatf("t_dValid_%0d", c), {31'b0, dValid}, 32'd0);
      check($sformatf("t_err_%0d", c), {31'b0, timeoutErr}, 32'd0);
    end
    step();
    memReady = 1'b1;
    #1;
    check("t_late_dValid", {31'b0, dValid}, 32'd1);
    check("t_late_dRData", dRData, 32'h55AA_55AA);
    check("t_late_err", {31'b0, timeoutErr}, 32'd0);
    step();
    dReq     = 1'b0;
    memReady = 1'b0;
    #1;
    check("t_idle_busy", {31'b0, busy}, 32'd0);
`endif

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
